mem_io_bridge: RTL and testbench
================================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter: FIFO_AW, 3, log2 of UART TX FIFO depth (depth = 2^FIFO_AW, min 2).
REQ-002 SHALL have port: clk_in  input  1  system clock; one clock, all state on rising edge.
REQ-003 SHALL have port: rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cpu_a  input  32  CPU address bus (bits 17:0 decoded).
REQ-005 SHALL have port: cpu_dout  input  8  CPU write data.
REQ-006 SHALL have port: cpu_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: cpu_din  output  8  read data returned to CPU.
REQ-008 SHALL have port: io_buffer_full  output  1  TX backpressure to CPU.
REQ-009 SHALL have ports: ram_a output 17, ram_din output 8, ram_wr output 1, ram_dout input 8 (RAM returns read data one cycle after address).
REQ-010 SHALL have ports: tx_data output 8, tx_valid output 1, tx_ready input 1 (UART transmitter).
REQ-011 SHALL have ports: rx_data input 8, rx_valid input 1, rx_pop output 1 (UART receiver).
REQ-012 SHALL have port: program_finish  output  1  sticky stop indication.

Function
REQ-013 SHALL decode io = (cpu_a[17:16] == 2'b11); all others are RAM accesses.
REQ-014 SHALL drive ram_a = cpu_a[16:0], ram_din = cpu_dout, ram_wr = cpu_wr & ~io combinationally.
REQ-015 SHALL register a read-source select each cycle; cpu_din in cycle N+1 SHALL reflect the access issued in cycle N (1-cycle latency, matching RAM).
REQ-016 RAM read: cpu_din = ram_dout in the following cycle.
REQ-017 Read 0x30000: if rx_valid, latch rx_data, pulse rx_pop for exactly that cycle, return byte next cycle; if not rx_valid, return 0x00, no pop.
REQ-018 Read 0x30004+k (k = cpu_a[1:0]): return byte k of the cycle counter, little-endian.
REQ-019 Cycle counter: 32-bit, increments every clock after reset, wraps 0xFFFFFFFF -> 0.
REQ-020 Write 0x30000 with nonzero data: push into TX FIFO; data 0x00 SHALL be ignored.
REQ-021 Write 0x30004: push 0x00 into TX FIFO (zero filter bypassed) and set stop_pending.
REQ-022 program_finish SHALL be stop_pending & FIFO empty, and remain 1 until reset.
REQ-023 tx_valid = FIFO not empty, tx_data = FIFO head; pop when tx_valid & tx_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-025 Push when full without same-cycle pop SHALL be dropped; FIFO contents unchanged.
REQ-026 io_buffer_full SHALL be 1 when count >= depth-1, leaving one slot for an in-flight write.
REQ-027 Other io addresses: reads return 0x00, writes ignored.
REQ-028 Head/tail pointers SHALL wrap modulo depth; count width FIFO_AW+1.

Reset
REQ-029 On rst_in: FIFO empty, pointers 0, counter 0, stop_pending 0, read select = RAM.
REQ-030 Reset outputs: tx_valid 0, rx_pop 0, io_buffer_full 0, program_finish 0, cpu_din = ram_dout.
REQ-031 Reset mid-operation SHALL discard queued TX bytes and any pending read return.

Configuration
REQ-032 Macro IO_CLK_SNAPSHOT_EN defined: read of 0x30004 (k=0) SHALL latch the full 32-bit counter into a snapshot; k=1..3 SHALL return snapshot bytes, giving a coherent value.
REQ-033 Macro IO_CLK_SNAPSHOT_EN undefined: all four bytes SHALL come from the live counter at the cycle of the read; no snapshot register.

Verification
REQ-034 RAM: write 0xA5 to 0x00010, read 0x00010 -> ram_wr pulse, cpu_din = 0xA5 one cycle after read.
REQ-035 UART TX: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only.
REQ-036 Backpressure: FIFO_AW=3, tx_ready=0, write 7 bytes -> io_buffer_full=1 after 7th; 9th write dropped; count stays 8.
REQ-037 Counter: read 0x30004..0x30007 on cycles 100..103 after reset -> with macro returns bytes of 100 (0x64,0,0,0); without, 0x64,0,0,0 with byte 0 from cycle 100.
REQ-038 Stop: tx_ready=0, write 0x30004 -> program_finish 0; raise tx_ready, 0x00 drains -> program_finish 1 next cycle, held.
REQ-039 RX: rx_valid=1, rx_data=0x7A, read 0x30000 -> rx_pop 1 cycle, cpu_din=0x7A next cycle; rx_valid=0 -> 0x00.

Source files
------------

// File: rtl/mem_io_bridge.sv
// CPU bus bridge: routes accesses to external RAM or to memory-mapped UART / cycle-counter IO.
// Optional macro IO_CLK_SNAPSHOT_EN: a byte-0 counter read snapshots the counter for coherent byte 1..3 reads.
module mem_io_bridge #(
   parameter int unsigned FIFO_AW = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_din,
   output logic        ram_wr,
   input  logic [7:0]  ram_dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_finish
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;
   localparam logic [17:0] ADDR_UART = 18'h30000;
   localparam logic [17:0] ADDR_CLK  = 18'h30004;

   typedef enum logic { SEL_RAM, SEL_IO } rd_sel_e;

   logic               io;
   logic               rd_uart;
   logic               rd_clk;
   logic               wr_uart;
   logic               wr_stop;
   logic [7:0]         io_rdata;
   logic [7:0]         io_rdata_q;
   rd_sel_e            rd_sel_q;
   logic [31:0]        cyc_cnt_q;
   logic [31:0]        clk_word;
   logic [7:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] head_q;
   logic [FIFO_AW-1:0] tail_q;
   logic [CW-1:0]      count_q;
   logic               fifo_empty;
   logic               fifo_full;
   logic               push;
   logic               pop;
   logic [7:0]         push_data;
   logic               stop_pending_q;
   logic               finish_q;
   logic [13:0]        unused_cpu_a;

   assign unused_cpu_a = cpu_a[31:18];

   // Address decode
   assign io      = (cpu_a[17:16] == 2'b11);
   assign rd_uart = io & ~cpu_wr & (cpu_a[17:0] == ADDR_UART);
   assign rd_clk  = io & ~cpu_wr & (cpu_a[17:2] == ADDR_CLK[17:2]);
   assign wr_uart = io & cpu_wr & (cpu_a[17:0] == ADDR_UART) & (cpu_dout != 8'h00);
   assign wr_stop = io & cpu_wr & (cpu_a[17:0] == ADDR_CLK);

   assign ram_a   = cpu_a[16:0];
   assign ram_din = cpu_dout;
   assign ram_wr  = cpu_wr & ~io;

   assign rx_pop  = rd_uart & rx_valid & ~rst_in;

`ifdef IO_CLK_SNAPSHOT_EN
   logic [31:0] snap_q;

   // Byte 0 reads live and captures the whole word for the following byte reads
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         snap_q <= '0;
      end else if (rd_clk && (cpu_a[1:0] == 2'b00)) begin
         snap_q <= cyc_cnt_q;
      end
   end

   assign clk_word = (cpu_a[1:0] == 2'b00) ? cyc_cnt_q : snap_q;
`else
   assign clk_word = cyc_cnt_q;
`endif

   // IO read data, captured for return one cycle later alongside RAM data
   always_comb begin
      io_rdata = 8'h00;
      if (rd_uart) begin
         io_rdata = rx_valid ? rx_data : 8'h00;
      end else if (rd_clk) begin
         io_rdata = clk_word[{cpu_a[1:0], 3'b000} +: 8];
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign pop        = ~fifo_empty & tx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push       = (wr_uart | wr_stop) & (~fifo_full | pop);
   assign push_data  = wr_stop ? 8'h00 : cpu_dout;

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[tail_q] <= push_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         cyc_cnt_q      <= '0;
         stop_pending_q <= 1'b0;
         finish_q       <= 1'b0;
         rd_sel_q       <= SEL_RAM;
         io_rdata_q     <= 8'h00;
      end else begin
         cyc_cnt_q  <= cyc_cnt_q + 32'd1;
         rd_sel_q   <= (io && !cpu_wr) ? SEL_IO : SEL_RAM;
         io_rdata_q <= io_rdata;
         if (push) begin
            tail_q <= tail_q + FIFO_AW'(1);
         end
         if (pop) begin
            head_q <= head_q + FIFO_AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
         if (wr_stop) begin
            stop_pending_q <= 1'b1;
         end
         if (stop_pending_q && fifo_empty) begin
            finish_q <= 1'b1;
         end
      end
   end

   assign cpu_din        = (rd_sel_q == SEL_IO) ? io_rdata_q : ram_dout;
   assign tx_valid       = ~fifo_empty;
   assign tx_data        = fifo_mem[head_q];
   // One slot of headroom for a write already in flight from the CPU
   assign io_buffer_full = (count_q >= CW'(DEPTH - 1));
   assign program_finish = finish_q | (stop_pending_q & fifo_empty);

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: scoreboard queues for CPU read data and UART TX bytes,
// drained by a negedge monitor running alongside the stimulus.
module tb_mem_io_bridge;

   localparam int unsigned FIFO_AW = 3;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic [7:0]  ram_din;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_finish;

   mem_io_bridge #(.FIFO_AW(FIFO_AW)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .cpu_a          (cpu_a),
      .cpu_dout       (cpu_dout),
      .cpu_wr         (cpu_wr),
      .cpu_din        (cpu_din),
      .io_buffer_full (io_buffer_full),
      .ram_a          (ram_a),
      .ram_din        (ram_din),
      .ram_wr         (ram_wr),
      .ram_dout       (ram_dout),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_pop         (rx_pop),
      .program_finish (program_finish)
   );

   initial forever #5 clk_in = ~clk_in;

   int unsigned tb_cyc = 0;
   always @(posedge clk_in) tb_cyc <= tb_cyc + 1;

   // RAM model, 1-cycle read latency; unwritten locations read as addr[7:0] ^ 0x5A
   bit [7:0] tb_ram [0:131071];
   always @(posedge clk_in) begin
      if (ram_wr) tb_ram[ram_a] <= ram_din ^ ram_a[7:0] ^ 8'h5A;
      ram_dout <= tb_ram[ram_a] ^ ram_a[7:0] ^ 8'h5A;
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  rd_exp_q [$];
   int unsigned rd_due_q [$];
   string       rd_tag_q [$];
   logic [7:0]  tx_exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      int unsigned due;
      logic [7:0]  exp;
      string       tag;
      forever begin
         @(negedge clk_in);
         while (rd_due_q.size() != 0 && rd_due_q[0] <= tb_cyc) begin
            due = rd_due_q.pop_front();
            exp = rd_exp_q.pop_front();
            tag = rd_tag_q.pop_front();
            if (due != tb_cyc) $display("FAIL %s: read checked late at cycle %0d, due %0d", tag, tb_cyc, due);
            chk(tag, 32'(cpu_din), 32'(exp));
         end
         if (tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got 0x%0h, want no byte", tx_data);
            end else begin
               exp = tx_exp_q.pop_front();
               chk("tx_data", 32'(tx_data), 32'(exp));
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus_idle();
      cpu_a    = 32'h0;
      cpu_wr   = 1'b0;
      cpu_dout = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic exp_ram_wr);
      cpu_a    = a;
      cpu_wr   = 1'b1;
      cpu_dout = d;
      #2;
      chk("ram_wr", 32'(ram_wr), 32'(exp_ram_wr));
      if (exp_ram_wr) begin
         chk("ram_a", 32'(ram_a), 32'(a[16:0]));
         chk("ram_din", 32'(ram_din), 32'(d));
      end
      tick();
      bus_idle();
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp, input logic exp_pop, input string tag);
      cpu_a  = a;
      cpu_wr = 1'b0;
      #2;
      chk({tag, "_rx_pop"}, 32'(rx_pop), 32'(exp_pop));
      rd_exp_q.push_back(exp);
      rd_due_q.push_back(tb_cyc + 1);
      rd_tag_q.push_back(tag);
      tick();
      bus_idle();
   endtask

   task automatic reset_dut();
      bus_idle();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   task automatic wait_tx_idle(input int max_cyc);
      int n;
      n = 0;
      while (tx_valid && n < max_cyc) begin
         tick();
         n++;
      end
      chk("tx_drain_timeout", 32'(tx_valid), 32'(0));
   endtask

   initial begin
      rst_in   = 1'b1;
      cpu_a    = 32'h0003_0000;
      cpu_wr   = 1'b0;
      cpu_dout = 8'h00;
      tx_ready = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h7A;
      fork
         monitor();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset state, with a UART read presented while reset is held
      tick();
      #2;
      chk("rst_rx_pop", 32'(rx_pop), 32'(0));
      tick();
      tick();
      #2;
      chk("rst_tx_valid", 32'(tx_valid), 32'(0));
      chk("rst_io_full", 32'(io_buffer_full), 32'(0));
      chk("rst_finish", 32'(program_finish), 32'(0));
      chk("rst_cpu_din", 32'(cpu_din), 32'(8'h5A));
      chk("rst_rx_pop2", 32'(rx_pop), 32'(0));
      rst_in   = 1'b0;
      rx_valid = 1'b0;
      bus_idle();

      // Cycle counter read on cycles 100..103 after reset
      repeat (100) tick();
      rd(32'h0003_0004, 8'h64, 1'b0, "clk_b0_c100");
      rd(32'h0003_0005, 8'h00, 1'b0, "clk_b1_c101");
      rd(32'h0003_0006, 8'h00, 1'b0, "clk_b2_c102");
      rd(32'h0003_0007, 8'h00, 1'b0, "clk_b3_c103");
      tick();

      // Counter reads straddling the 255 -> 256 carry
      reset_dut();
      repeat (255) tick();
      rd(32'h0003_0004, 8'hFF, 1'b0, "clk_b0_c255");
`ifdef IO_CLK_SNAPSHOT_EN
      rd(32'h0003_0005, 8'h00, 1'b0, "clk_b1_snap255");
`else
      rd(32'h0003_0005, 8'h01, 1'b0, "clk_b1_c256");
`endif
      rd(32'h0003_0006, 8'h00, 1'b0, "clk_b2");
      rd(32'h0003_0007, 8'h00, 1'b0, "clk_b3");
      tick();

      // RAM path, including the bit-16 and bits 17:16 = 10 aliases
      wr(32'h0000_0010, 8'hA5, 1'b1);
      rd(32'h0000_0010, 8'hA5, 1'b0, "ram_rd_10");
      wr(32'h0001_FFFF, 8'h3C, 1'b1);
      rd(32'h0001_FFFF, 8'h3C, 1'b0, "ram_rd_1ffff");
      rd(32'h0002_0010, 8'hA5, 1'b0, "ram_rd_alias");
      rd(32'h0000_0123, 8'h79, 1'b0, "ram_rd_unwritten");
      tick();

      // UART TX with the zero filter
      tx_ready = 1'b1;
      wr(32'h0003_0000, 8'h41, 1'b0);
      tx_exp_q.push_back(8'h41);
      wr(32'h0003_0000, 8'h00, 1'b0);
      wr(32'h0003_0000, 8'h42, 1'b0);
      tx_exp_q.push_back(8'h42);
      wait_tx_idle(20);
      chk("tx_seq_left", 32'(tx_exp_q.size()), 32'(0));

      // Backpressure, drop on full, simultaneous push/pop at full
      tx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         wr(32'h0003_0000, 8'(i), 1'b0);
         tx_exp_q.push_back(8'(i));
      end
      chk("full_after6", 32'(io_buffer_full), 32'(0));
      wr(32'h0003_0000, 8'h07, 1'b0);
      tx_exp_q.push_back(8'h07);
      chk("full_after7", 32'(io_buffer_full), 32'(1));
      wr(32'h0003_0000, 8'h08, 1'b0);
      tx_exp_q.push_back(8'h08);
      wr(32'h0003_0000, 8'h99, 1'b0);
      chk("full_after9", 32'(io_buffer_full), 32'(1));
      chk("head_after9", 32'(tx_data), 32'(8'h01));
      tx_ready = 1'b1;
      wr(32'h0003_0000, 8'h55, 1'b0);
      tx_exp_q.push_back(8'h55);
      chk("full_push_pop", 32'(io_buffer_full), 32'(1));
      wait_tx_idle(30);
      chk("bp_seq_left", 32'(tx_exp_q.size()), 32'(0));

      // UART RX, other IO addresses, zero write ignored
      rx_data  = 8'h7A;
      rx_valid = 1'b1;
      rd(32'h0003_0000, 8'h7A, 1'b1, "rx_valid_rd");
      #2;
      chk("rx_pop_idle", 32'(rx_pop), 32'(0));
      rx_valid = 1'b0;
      rd(32'h0003_0000, 8'h00, 1'b0, "rx_empty_rd");
      rd(32'h0003_0010, 8'h00, 1'b0, "io_other_rd");
      tx_ready = 1'b0;
      wr(32'h0003_0008, 8'h77, 1'b0);
      wr(32'h0003_0000, 8'h00, 1'b0);
      chk("io_ignored_writes", 32'(tx_valid), 32'(0));

      // Stop: finish waits for the 0x00 marker to drain, then stays set
      wr(32'h0003_0004, 8'hFF, 1'b0);
      tx_exp_q.push_back(8'h00);
      chk("stop_tx_valid", 32'(tx_valid), 32'(1));
      chk("stop_finish0", 32'(program_finish), 32'(0));
      tick();
      chk("stop_finish0b", 32'(program_finish), 32'(0));
      tx_ready = 1'b1;
      tick();
      chk("stop_finish1", 32'(program_finish), 32'(1));
      tx_ready = 1'b0;
      repeat (3) tick();
      chk("stop_finish_hold", 32'(program_finish), 32'(1));
      tx_ready = 1'b1;
      wr(32'h0003_0000, 8'h33, 1'b0);
      tx_exp_q.push_back(8'h33);
      chk("stop_finish_sticky", 32'(program_finish), 32'(1));
      wait_tx_idle(20);
      reset_dut();
      chk("finish_cleared", 32'(program_finish), 32'(0));

      // Reset mid-operation discards queued TX bytes and the in-flight UART read
      tx_ready = 1'b0;
      wr(32'h0003_0000, 8'h11, 1'b0);
      wr(32'h0003_0000, 8'h22, 1'b0);
      wr(32'h0003_0000, 8'h33, 1'b0);
      chk("mid_queued", 32'(tx_valid), 32'(1));
      cpu_a    = 32'h0003_0000;
      cpu_wr   = 1'b0;
      rx_data  = 8'h7A;
      rx_valid = 1'b1;
      rst_in   = 1'b1;
      #2;
      chk("mid_rst_rx_pop", 32'(rx_pop), 32'(0));
      rd_exp_q.push_back(8'h5A);
      rd_due_q.push_back(tb_cyc + 1);
      rd_tag_q.push_back("mid_rst_rd_discard");
      tick();
      bus_idle();
      tick();
      rst_in   = 1'b0;
      rx_valid = 1'b0;
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'(0));
      tx_ready = 1'b1;
      repeat (5) tick();

      chk("tx_leftover", 32'(tx_exp_q.size()), 32'(0));
      chk("rd_leftover", 32'(rd_due_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
